// File: rtl/mem_bus_if.sv
// Request, response, snoop-broadcast and memory-port bundle for mem_bus_ctrl.
// SNOOP_FLUSH_EN adds the snoop_flush / snoop_fdata inputs.
interface mem_bus_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 16
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      bus_valid;
  logic                      bus_wr;
  logic [TAG_W-1:0]          bus_tag;
  logic [1:0]                bus_src;
  logic [TAG_W-1:0]          m_tag;
  logic                      m_enable;
  logic                      m_w_enable;
  logic [DATA_W-1:0]         m_data_in;
  logic [DATA_W-1:0]         m_data_out;
`ifdef SNOOP_FLUSH_EN
  logic [NUM_REQ-1:0]        snoop_flush;
  logic [NUM_REQ*DATA_W-1:0] snoop_fdata;
`endif

  // Controller side.
  modport master (
`ifdef SNOOP_FLUSH_EN
    input  snoop_flush, snoop_fdata,
`endif
    input  req_valid, req_wr, req_tag, req_wdata, m_data_out,
    output req_ready, resp_valid, resp_rdata, bus_valid, bus_wr, bus_tag, bus_src,
    output m_tag, m_enable, m_w_enable, m_data_in
  );

  // Requester / memory side.
  modport slave (
`ifdef SNOOP_FLUSH_EN
    output snoop_flush, snoop_fdata,
`endif
    output req_valid, req_wr, req_tag, req_wdata, m_data_out,
    input  req_ready, resp_valid, resp_rdata, bus_valid, bus_wr, bus_tag, bus_src,
    input  m_tag, m_enable, m_w_enable, m_data_in
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Round-robin shared-bus controller in front of the backing memory.
// IDLE -> SNOOP -> ACCESS (ACCESS_CYCLES) -> RESP -> IDLE.
// Optional macro SNOOP_FLUSH_EN: a Modified holder may flush its line during SNOOP,
// turning a read into a memory write of the flushed data.
module mem_bus_ctrl #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned TAG_W         = 3,
  parameter int unsigned DATA_W        = 16
) (
  input logic       clk,
  input logic       rst_n,
  mem_bus_if.master mb
);
  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSnoop, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, src_q, grant_idx;
  logic                grant_vld;
  logic                wr_q, flush_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                flush_hit;
  logic [DATA_W-1:0]   flush_data;

  // Round-robin search upward from rr_ptr with wrap-around.
  always_comb begin : p_grant
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!grant_vld && mb.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(idx);
      end
    end
  end

`ifdef SNOOP_FLUSH_EN
  // Lowest-index flusher other than the current owner wins.
  always_comb begin
    flush_hit  = 1'b0;
    flush_data = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!flush_hit && mb.snoop_flush[j] && (2'(j) != src_q)) begin
        flush_hit  = 1'b1;
        flush_data = mb.snoop_fdata[j*DATA_W +: DATA_W];
      end
    end
  end
`else
  assign flush_hit  = 1'b0;
  assign flush_data = '0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (grant_vld) state_d = StSnoop;
      StSnoop:  state_d = StAccess;
      StAccess: if (cnt_q == '0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Transaction registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      src_q    <= '0;
      wr_q     <= 1'b0;
      flush_q  <= 1'b0;
      tag_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_vld) begin
            src_q   <= grant_idx;
            wr_q    <= mb.req_wr[grant_idx];
            tag_q   <= mb.req_tag[grant_idx*TAG_W +: TAG_W];
            wdata_q <= mb.req_wdata[grant_idx*DATA_W +: DATA_W];
            flush_q <= 1'b0;
            rdata_q <= '0;
          end
        end
        StSnoop: begin
          cnt_q <= CNT_W'(ACCESS_CYCLES - 1);
          // A flushed line is written back and also returned to the reader.
          if (!wr_q && flush_hit) begin
            flush_q <= 1'b1;
            wdata_q <= flush_data;
            rdata_q <= flush_data;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            if (!wr_q && !flush_q) rdata_q <= mb.m_data_out;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: rr_ptr_q <= (src_q == 2'(NUM_REQ - 1)) ? 2'd0 : src_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Decoded outputs; everything idles at zero.
  always_comb begin
    mb.req_ready  = '0;
    mb.resp_valid = '0;
    mb.resp_rdata = '0;
    mb.bus_valid  = 1'b0;
    mb.bus_wr     = 1'b0;
    mb.bus_tag    = '0;
    mb.bus_src    = '0;
    mb.m_tag      = '0;
    mb.m_enable   = 1'b0;
    mb.m_w_enable = 1'b0;
    mb.m_data_in  = '0;
    case (state_q)
      StIdle: if (grant_vld && rst_n) mb.req_ready[grant_idx] = 1'b1;
      StSnoop: begin
        mb.bus_valid = 1'b1;
        mb.bus_wr    = wr_q;
        mb.bus_tag   = tag_q;
        mb.bus_src   = src_q;
      end
      StAccess: begin
        mb.m_enable   = 1'b1;
        mb.m_tag      = tag_q;
        mb.m_w_enable = wr_q | flush_q;
        mb.m_data_in  = wdata_q;
      end
      StResp: begin
        mb.resp_valid[src_q] = 1'b1;
        mb.resp_rdata        = wr_q ? '0 : rdata_q;
      end
      default: ;
    endcase
  end
endmodule
